// File: rtl/mult_div_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencing controller.
// Optional early divide-by-zero exit is selected with MULT_DIV_DIV0_EARLY_EXIT_EN.
package mult_div_pkg;

  localparam int CNT_W      = 32;
  localparam int MULT_STEPS = 16;
  localparam int DIV_STEPS  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_ctrl.sv
// Sequencing controller for the multicycle multiplier/divider; drives the external iteration counter.
// Define MULT_DIV_DIV0_EARLY_EXIT_EN to finish a divide by zero straight after LOAD.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int CNT_W      = mult_div_pkg::CNT_W,
  parameter int MULT_STEPS = mult_div_pkg::MULT_STEPS,
  parameter int DIV_STEPS  = mult_div_pkg::DIV_STEPS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [CNT_W-1:0] count_in,
  input  logic             divisor_zero,
  input  logic             overflow_in,
  output logic [CNT_W-1:0] count_next,
  output logic             count_we,
  output logic             count_oe,
  output logic             count_clr,
  output logic             op_is_div,
  output logic             load_operands,
  output logic             step_en,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_opIsDiv;
  logic             r_div0;
  logic             r_fault;
  logic             w_start;
  logic [CNT_W-1:0] w_lastIdx;
  logic             w_lastStep;
  logic             w_overrun;

  assign w_start    = ctrl_MULT | ctrl_DIV;
  assign w_lastIdx  = r_opIsDiv ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MULT_STEPS - 1);
  assign w_lastStep = (count_in >= w_lastIdx);
  assign w_overrun  = (count_in > w_lastIdx);
  assign op_is_div  = r_opIsDiv;

  // A counter value past the terminal index can only come from a fault; remember it for DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_opIsDiv <= 1'b0;
      r_div0    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_start) begin
        r_opIsDiv <= ctrl_DIV & ~ctrl_MULT;
      end
      if (r_state == LOAD) begin
        r_div0 <= divisor_zero;
      end
      if (w_start) begin
        r_fault <= 1'b0;
      end else if (r_state == RUN && w_overrun) begin
        r_fault <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState    = r_state;
    count_next     = '0;
    count_we       = 1'b0;
    count_oe       = 1'b0;
    count_clr      = 1'b0;
    load_operands  = 1'b0;
    step_en        = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextState = IDLE;
      end
      LOAD: begin
        load_operands = 1'b1;
        count_clr     = 1'b1;
        count_oe      = 1'b1;
        busy          = 1'b1;
        w_nextState   = RUN;
`ifdef MULT_DIV_DIV0_EARLY_EXIT_EN
        if (r_opIsDiv && divisor_zero) begin
          w_nextState = DONE;
        end
`endif
      end
      RUN: begin
        step_en    = 1'b1;
        count_we   = 1'b1;
        count_oe   = 1'b1;
        busy       = 1'b1;
        count_next = count_in + CNT_W'(1);
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        data_resultRDY = 1'b1;
        count_oe       = 1'b1;
        data_exception = r_fault | (r_opIsDiv ? r_div0 : overflow_in);
        w_nextState    = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    // A new start overrides whatever is in flight.
    if (w_start) begin
      w_nextState = LOAD;
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl with a behavioural model of the external iteration counter.
// Honours MULT_DIV_DIV0_EARLY_EXIT_EN for the divide-by-zero expectation.
module tb_mult_div_ctrl;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] count_in;
  logic        divisor_zero;
  logic        overflow_in;
  logic [31:0] count_next;
  logic        count_we;
  logic        count_oe;
  logic        count_clr;
  logic        op_is_div;
  logic        load_operands;
  logic        step_en;
  logic        busy;
  logic        data_resultRDY;
  logic        data_exception;

  typedef struct {
    int   startCycle;
    int   lat;
    logic exc;
    logic isDiv;
    int   steps;
  } exp_t;

  exp_t        sbq[$];
  int          checks;
  int          failures;
  int          cycleCnt;
  int          stepCount;
  logic [31:0] cntReg;
  logic        faultMode;

  mult_div_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .count_in       (count_in),
    .divisor_zero   (divisor_zero),
    .overflow_in    (overflow_in),
    .count_next     (count_next),
    .count_we       (count_we),
    .count_oe       (count_oe),
    .count_clr      (count_clr),
    .op_is_div      (op_is_div),
    .load_operands  (load_operands),
    .step_en        (step_en),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // External counter register: clear wins over write enable.
  always @(posedge clock) begin
    if (count_clr) cntReg <= '0;
    else if (count_we) cntReg <= count_next;
  end

  assign count_in = faultMode ? 32'd100 : (count_oe ? cntReg : 32'd0);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic d, input logic dz, input logic ov,
                               input int lat, input logic exc, input logic isDiv, input int steps);
    exp_t e;
    @(negedge clock);
    ctrl_MULT    = m;
    ctrl_DIV     = d;
    divisor_zero = dz;
    overflow_in  = ov;
    e.startCycle = cycleCnt + 1;
    e.lat        = lat;
    e.exc        = exc;
    e.isDiv      = isDiv;
    e.steps      = steps;
    sbq.delete();
    sbq.push_back(e);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clock);
    if (sbq.size() != 0) begin
      checkOutput("timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  function automatic logic [40:0] outVec();
    return {count_next, count_we, count_oe, count_clr, op_is_div, load_operands,
            step_en, busy, data_resultRDY, data_exception};
  endfunction

  // Monitor: load timing, per-step counter walk, and result/exception against the scoreboard.
  always @(negedge clock) begin
    if (reset_n) begin
      if (load_operands) begin
        if (sbq.size() == 0) checkOutput("spurious_load", 64'd1, 64'd0);
        else checkOutput("load_lat", 64'(cycleCnt - sbq[0].startCycle + 1), 64'd1);
        stepCount = 0;
      end
      if (step_en) begin
        checkOutput("count_next", 64'(count_next), faultMode ? 64'd101 : 64'(stepCount + 1));
        checkOutput("run_flags", 64'({busy, count_we, count_oe}), 64'b111);
        stepCount++;
      end
      if (data_resultRDY) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_rdy", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("rdy_lat", 64'(cycleCnt - e.startCycle + 1), 64'(e.lat));
          checkOutput("rdy_exc", 64'(data_exception), 64'(e.exc));
          checkOutput("rdy_opdiv", 64'(op_is_div), 64'(e.isDiv));
          checkOutput("rdy_steps", 64'(stepCount), 64'(e.steps));
          checkOutput("done_flags", 64'({busy, count_oe}), 64'b01);
        end
      end else if (data_exception) begin
        checkOutput("exc_unqualified", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    cycleCnt     = 0;
    stepCount    = 0;
    faultMode    = 1'b0;
    reset_n      = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    divisor_zero = 1'b0;
    overflow_in  = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", 64'(outVec()), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] multiply, no overflow");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 18, 1'b0, 1'b0, 16);
    waitDone();

    $display("[TB] divide, nonzero divisor");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 34, 1'b0, 1'b1, 32);
    waitDone();

    $display("[TB] divide by zero");
`ifdef MULT_DIV_DIV0_EARLY_EXIT_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 0);
`else
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 34, 1'b1, 1'b1, 32);
`endif
    waitDone();

    $display("[TB] multiply abandoned by divide at E+8");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 18, 1'b0, 1'b0, 16);
    repeat (6) @(negedge clock);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 34, 1'b0, 1'b1, 32);
    waitDone();

    $display("[TB] simultaneous start resolves to multiply, overflow set");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 18, 1'b1, 1'b0, 16);
    waitDone();

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 34, 1'b0, 1'b1, 32);
    repeat (8) @(negedge clock);
    #2;
    reset_n = 1'b0;
    sbq.delete();
    #1;
    checkOutput("async_reset_outputs", 64'(outVec()), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 18, 1'b0, 1'b0, 16);
    waitDone();

    $display("[TB] counter overrun fault");
    faultMode = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1);
    waitDone();
    faultMode = 1'b0;

    checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);
    checkOutput("idle_outputs", 64'(outVec()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
